// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: bus mode, default fill byte and bit counter width.
package spi_pkg;
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;
   localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;
   localparam int BIT_CNT_W = 3;

   typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer with a trailing flop for single-cycle edge detection.
module spi_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic CLKX4,
   input  logic nRESET,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave_if.sv
// SPI mode 0 responder oversampled in the CLKX4 domain, with a one-byte rx register and tx holding buffer.
// state     | meaning
// ST_IDLE   | nCS_s high; SCLK ignored, bit counter parked at 0, MISO released
// ST_ACTIVE | selected; sample on SCLK rise, shift/reload on SCLK fall
module spi_slave_if
   import spi_pkg::*;
#(
   parameter logic [7:0] FILL_BYTE   = DEFAULT_FILL_BYTE,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       CLKX4,
   input  logic       nRESET,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic       nCS,
   output logic       MISO,
   output logic       MISO_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_ready,
   output logic       tx_underrun,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       busy
);
   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ACTIVE = 1'b1;

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic ncs_level_unused, ncs_rise, ncs_fall;
   logic sclk_sample, sclk_shift, mosi_s;
   logic [SYNC_STAGES-1:0] mosi_sync_q;

   logic       state_q, state_d;
   bit_cnt_t   bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_overrun_q, rx_overrun_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] tx_buf_q, tx_buf_d;
   logic       tx_full_q, tx_full_d;
   logic       tx_underrun_q, tx_underrun_d;
   logic       reload;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
      .CLKX4(CLKX4), .nRESET(nRESET), .d_i(SCLK),
      .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
      .CLKX4(CLKX4), .nRESET(nRESET), .d_i(nCS),
      .level_o(ncs_level_unused), .rise_o(ncs_rise), .fall_o(ncs_fall)
   );

   // MOSI gets the same depth as SCLK so the detected edge lines up with its data bit
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         mosi_sync_q <= '0;
      end else begin
         mosi_sync_q[0] <= MOSI;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            mosi_sync_q[i] <= mosi_sync_q[i-1];
         end
      end
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sclk_sample = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
   assign sclk_shift  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      rx_overrun_d  = rx_overrun_q;
      tx_shift_d    = tx_shift_q;
      tx_buf_d      = tx_buf_q;
      tx_full_d     = tx_full_q;
      tx_underrun_d = 1'b0;
      reload        = 1'b0;

      if (rx_ack && rx_valid_q) begin
         rx_valid_d   = 1'b0;
         rx_overrun_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d = '0;
            if (ncs_fall) begin
               state_d = ST_ACTIVE;
               reload  = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (ncs_rise) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
            end else begin
               if (sclk_sample) begin
                  rx_shift_d = {rx_shift_q[5:0], mosi_s};
                  bit_cnt_d  = bit_cnt_q + bit_cnt_t'(1);
                  if (bit_cnt_q == '1) begin
                     rx_data_d  = {rx_shift_q, mosi_s};
                     rx_valid_d = 1'b1;
                     if (rx_valid_q && !rx_ack) begin
                        rx_overrun_d = 1'b1;
                     end
                  end
               end
               if (sclk_shift) begin
                  if (bit_cnt_q == '0) begin
                     reload = 1'b1;
                  end else begin
                     tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (reload) begin
         tx_shift_d    = tx_full_q ? tx_buf_q : FILL_BYTE;
         tx_underrun_d = ~tx_full_q;
         tx_full_d     = 1'b0;
      end

      // write is qualified on the registered flag, so a coincident reload from an empty buffer still fills
      if (tx_wr && !tx_full_q) begin
         tx_buf_d  = tx_data;
         tx_full_d = 1'b1;
      end
   end

   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_overrun_q  <= 1'b0;
         tx_shift_q    <= FILL_BYTE;
         tx_buf_q      <= '0;
         tx_full_q     <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         rx_overrun_q  <= rx_overrun_d;
         tx_shift_q    <= tx_shift_d;
         tx_buf_q      <= tx_buf_d;
         tx_full_q     <= tx_full_d;
         tx_underrun_q <= tx_underrun_d;
      end
   end

   assign MISO        = tx_shift_q[7];
   assign MISO_oe     = (state_q == ST_ACTIVE);
   assign busy        = (state_q == ST_ACTIVE);
   assign tx_ready    = ~tx_full_q;
   assign tx_underrun = tx_underrun_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_overrun  = rx_overrun_q;
endmodule
